// File: rtl/robo_atuador.sv
// robo_atuador: executes navigation commands (forward, turn, remove) as timed motor pulses
// and keeps grid odometry, heading, a removal counter and a sticky error flag.
`default_nettype none

module robo_atuador #(
  parameter int T_AVANCO  = 4,
  parameter int T_GIRO    = 3,
  parameter int T_REMOCAO = 6,
  parameter int GRID_MAX  = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       avancar,
  input  logic       girar,
  input  logic       remover,
  output logic       motor_frente,
  output logic       motor_giro,
  output logic       garra,
  output logic       ocupado,
  output logic       concluido,
  output logic [1:0] direcao,
  output logic [3:0] pos_x,
  output logic [3:0] pos_y,
  output logic [7:0] remocoes,
  output logic       erro
);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    AVANCANDO = 2'd1,
    GIRANDO   = 2'd2,
    REMOVENDO = 2'd3
  } state_t;

  localparam logic [7:0] CNT_AVANCO  = 8'(T_AVANCO - 1);
  localparam logic [7:0] CNT_GIRO    = 8'(T_GIRO - 1);
  localparam logic [7:0] CNT_REMOCAO = 8'(T_REMOCAO - 1);
  localparam logic [3:0] GRID_LIM    = 4'(GRID_MAX);

  state_t     state, state_next;
  logic [7:0] count, count_next;
  logic       concluido_next;
  logic [1:0] direcao_next;
  logic [3:0] pos_x_next, pos_y_next;
  logic [7:0] remocoes_next;
  logic       erro_next;
  logic       conflito;

  // Two or more commands at once is a navigation fault, even though one still runs.
  assign conflito = (avancar & girar) | (avancar & remover) | (girar & remover);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= OCIOSO;
      count     <= 8'd0;
      concluido <= 1'b0;
      direcao   <= 2'd0;
      pos_x     <= 4'd0;
      pos_y     <= 4'd0;
      remocoes  <= 8'd0;
      erro      <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      concluido <= concluido_next;
      direcao   <= direcao_next;
      pos_x     <= pos_x_next;
      pos_y     <= pos_y_next;
      remocoes  <= remocoes_next;
      erro      <= erro_next;
    end
  end

  always_comb begin
    state_next     = state;
    count_next     = count;
    concluido_next = 1'b0;
    direcao_next   = direcao;
    pos_x_next     = pos_x;
    pos_y_next     = pos_y;
    remocoes_next  = remocoes;
    erro_next      = erro;

    if (state == OCIOSO) begin
      if (conflito) erro_next = 1'b1;
      if (remover) begin
        state_next = REMOVENDO;
        count_next = CNT_REMOCAO;
      end else if (girar) begin
        state_next = GIRANDO;
        count_next = CNT_GIRO;
      end else if (avancar) begin
        state_next = AVANCANDO;
        count_next = CNT_AVANCO;
      end
    end else if (count != 8'd0) begin
      count_next = count - 8'd1;
    end else begin
      // Final cycle of the operation: commit its effect and flag completion.
      state_next     = OCIOSO;
      concluido_next = 1'b1;
      case (state)
        AVANCANDO: begin
          case (direcao)
            2'd0: if (pos_y == GRID_LIM) erro_next = 1'b1; else pos_y_next = pos_y + 4'd1;
            2'd1: if (pos_x == GRID_LIM) erro_next = 1'b1; else pos_x_next = pos_x + 4'd1;
            2'd2: if (pos_y == 4'd0)     erro_next = 1'b1; else pos_y_next = pos_y - 4'd1;
            default: if (pos_x == 4'd0)  erro_next = 1'b1; else pos_x_next = pos_x - 4'd1;
          endcase
        end
        GIRANDO: direcao_next = direcao + 2'd1;
        REMOVENDO: if (remocoes != 8'hFF) remocoes_next = remocoes + 8'd1;
        default: ;
      endcase
    end
  end

  assign motor_frente = (state == AVANCANDO);
  assign motor_giro   = (state == GIRANDO);
  assign garra        = (state == REMOVENDO);
  assign ocupado      = (state != OCIOSO);

endmodule

`default_nettype wire

// File: tb/tb_robo_atuador.sv
// tb_robo_atuador: scenario tasks plus a randomized run checked against a cycle-level reference model.
`default_nettype none

module tb_robo_atuador;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       avancar = 1'b0, girar = 1'b0, remover = 1'b0;
  logic       motor_frente, motor_giro, garra, ocupado, concluido, erro;
  logic [1:0] direcao;
  logic [3:0] pos_x, pos_y;
  logic [7:0] remocoes;

  int total = 0;
  int bad   = 0;

  robo_atuador #(.T_AVANCO(4), .T_GIRO(3), .T_REMOCAO(6), .GRID_MAX(15)) dut (
    .clock(clock), .reset(reset), .avancar(avancar), .girar(girar), .remover(remover),
    .motor_frente(motor_frente), .motor_giro(motor_giro), .garra(garra), .ocupado(ocupado),
    .concluido(concluido), .direcao(direcao), .pos_x(pos_x), .pos_y(pos_y),
    .remocoes(remocoes), .erro(erro)
  );

  always #5 clock = ~clock;

  // Reference model: remaining busy cycles and a pending operation kind (1 fwd, 2 turn, 3 remove).
  int m_left, m_op, m_x, m_y, m_dir, m_rem;
  bit m_err, m_done;

  task automatic model_reset();
    m_left = 0; m_op = 0; m_x = 0; m_y = 0; m_dir = 0; m_rem = 0; m_err = 0; m_done = 0;
  endtask

  task automatic model_step(input bit a, input bit g, input bit r);
    m_done = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1;
        if (m_op == 1) begin
          int nx, ny;
          nx = m_x + ((m_dir == 1) ? 1 : (m_dir == 3) ? -1 : 0);
          ny = m_y + ((m_dir == 0) ? 1 : (m_dir == 2) ? -1 : 0);
          if (nx < 0 || nx > 15 || ny < 0 || ny > 15) m_err = 1;
          else begin m_x = nx; m_y = ny; end
        end else if (m_op == 2) m_dir = (m_dir + 1) % 4;
        else if (m_rem < 255) m_rem++;
        m_op = 0;
      end
    end else if (a || g || r) begin
      if (int'(a) + int'(g) + int'(r) > 1) m_err = 1;
      if (r)      begin m_op = 3; m_left = 6; end
      else if (g) begin m_op = 2; m_left = 3; end
      else        begin m_op = 1; m_left = 4; end
    end
  endtask

  function automatic logic [24:0] model_vec();
    return {m_op == 1 && m_left > 0, m_op == 2 && m_left > 0, m_op == 3 && m_left > 0,
            m_left > 0, m_done, 2'(m_dir), 4'(m_x), 4'(m_y), 8'(m_rem), m_err};
  endfunction

  function automatic logic [24:0] dut_vec();
    return {motor_frente, motor_giro, garra, ocupado, concluido, direcao, pos_x, pos_y, remocoes, erro};
  endfunction

  task automatic tick(input bit a, input bit g, input bit r);
    avancar = a; girar = g; remover = r;
    @(posedge clock);
    model_step(a, g, r);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    avancar = 0; girar = 0; remover = 0;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    total++;
    if (dut_vec() !== 25'd0) begin
      bad++; $display("FAIL reset_state: got %h expected %h", dut_vec(), 25'd0);
    end
    do_reset();
  endtask

  task automatic test_avanco();
    int hi = 0, oc = 0, conc_at = -1, nconc = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick(i == 0, 0, 0);
      hi += int'(motor_frente); oc += int'(ocupado);
      if (concluido) begin nconc++; conc_at = i; end
    end
    total++; if (hi != 4) begin bad++; $display("FAIL avanco_cycles: got %0d expected 4", hi); end
    total++; if (oc != 4) begin bad++; $display("FAIL avanco_ocupado: got %0d expected 4", oc); end
    total++; if (nconc != 1 || conc_at != 4) begin
      bad++; $display("FAIL avanco_concluido: got count %0d at %0d expected 1 at 4", nconc, conc_at);
    end
    total++; if ({pos_x, pos_y, erro} !== {4'd0, 4'd1, 1'b0}) begin
      bad++; $display("FAIL avanco_pos: got x=%0d y=%0d erro=%0d expected x=0 y=1 erro=0", pos_x, pos_y, erro);
    end
  endtask

  task automatic test_giro();
    int hi = 0, k = 0;
    logic [1:0] exp_dir [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(0, 1, 0);
      hi += int'(motor_giro);
      if (concluido) begin
        total++;
        if (i != 4 * k + 3 || k > 4 || direcao !== exp_dir[k % 5]) begin
          bad++; $display("FAIL giro_step: tick %0d op %0d got dir %0d", i, k, direcao);
        end
        k++;
      end
    end
    girar = 0;
    total++; if (hi != 15 || k != 5) begin
      bad++; $display("FAIL giro_total: got %0d cycles %0d ops expected 15 cycles 5 ops", hi, k);
    end
  endtask

  task automatic test_conflito();
    int hi = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick(i == 0, 0, i == 0);
      hi += int'(garra);
      total++; if (motor_frente !== 1'b0) begin bad++; $display("FAIL conflito_frente: got 1 expected 0"); end
    end
    total++; if (hi != 6) begin bad++; $display("FAIL conflito_garra: got %0d expected 6", hi); end
    total++; if ({remocoes, pos_x, pos_y, erro} !== {8'd1, 4'd0, 4'd0, 1'b1}) begin
      bad++; $display("FAIL conflito_state: got rem=%0d x=%0d y=%0d erro=%0d expected 1 0 0 1",
                      remocoes, pos_x, pos_y, erro);
    end
  endtask

  task automatic test_parede();
    int hi = 0;
    do_reset();
    for (int i = 0; i < 12; i++) tick(i % 4 == 0, 0, 0) ;
    do_reset();
    for (int i = 0; i < 12; i++) tick(0, i % 4 == 0, 0);
    total++; if (direcao !== 2'd3) begin bad++; $display("FAIL parede_dir: got %0d expected 3", direcao); end
    for (int i = 0; i < 6; i++) begin
      tick(i == 0, 0, 0);
      hi += int'(motor_frente);
    end
    total++; if ({pos_x, pos_y, erro} !== {4'd0, 4'd0, 1'b1} || hi != 4) begin
      bad++; $display("FAIL parede: got x=%0d y=%0d erro=%0d cycles=%0d expected 0 0 1 4", pos_x, pos_y, erro, hi);
    end
  endtask

  task automatic test_reset_meio();
    bit seen = 0;
    do_reset();
    tick(0, 0, 1); tick(0, 0, 0); tick(0, 0, 0);
    total++; if (garra !== 1'b1) begin bad++; $display("FAIL meio_garra_on: got %b expected 1", garra); end
    reset = 1'b1;
    model_reset();
    #1;
    total++; if (dut_vec() !== 25'd0) begin
      bad++; $display("FAIL meio_reset_imediato: got %h expected %h", dut_vec(), 25'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    tick(1, 0, 0);
    total++; if ({motor_frente, ocupado} !== 2'b11) begin
      bad++; $display("FAIL meio_primeira_borda: got %b expected 11", {motor_frente, ocupado});
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0);
      if (concluido && i != 3) seen = 1;
    end
    total++; if (seen || remocoes !== 8'd0 || pos_y !== 4'd1) begin
      bad++; $display("FAIL meio_pos_reset: got early_conc=%0d rem=%0d y=%0d expected 0 0 1", seen, remocoes, pos_y);
    end
  endtask

  task automatic test_ignorado();
    bit giro_seen = 0;
    do_reset();
    tick(1, 0, 0);
    tick(0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0);
      if (motor_giro) giro_seen = 1;
    end
    total++; if (giro_seen || direcao !== 2'd0 || pos_y !== 4'd1) begin
      bad++; $display("FAIL ignorado: got giro=%0d dir=%0d y=%0d expected 0 0 1", giro_seen, direcao, pos_y);
    end
  endtask

  task automatic test_saturacao();
    do_reset();
    for (int i = 0; i < 260 * 7; i++) tick(0, 0, 1);
    remover = 0;
    total++; if (remocoes !== 8'd255) begin
      bad++; $display("FAIL saturacao: got %0d expected 255", remocoes);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int v;
      v = $urandom_range(0, 15);
      tick(v == 1 || v == 5 || v > 11, v == 2 || v == 6, v == 3 || (v == 7 && i % 3 == 0));
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL random_tick%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_avanco();
    test_giro();
    test_conflito();
    test_parede();
    test_reset_meio();
    test_ignorado();
    test_saturacao();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/robo_atuador.md
ROBO_ATUADOR -- requirements
Module: robo_atuador

Interface
REQ-001 Parameter T_AVANCO, default 4, cycles the forward motor stays on per accepted avancar (legal 1..255).
REQ-002 Parameter T_GIRO, default 3, cycles the turn motor stays on per accepted girar (legal 1..255).
REQ-003 Parameter T_REMOCAO, default 6, cycles the gripper stays on per accepted remover (legal 1..255).
REQ-004 Parameter GRID_MAX, default 15, maximum coordinate on each axis (legal 1..15).
REQ-005 clock  input  1  system clock, all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 avancar  input  1  move-forward command from the navigation FSM, level-sampled.
REQ-008 girar  input  1  turn command from the navigation FSM, level-sampled.
REQ-009 remover  input  1  remove-object command from the navigation FSM, level-sampled.
REQ-010 motor_frente  output  1  forward motor drive.
REQ-011 motor_giro  output  1  turn motor drive.
REQ-012 garra  output  1  gripper drive.
REQ-013 ocupado  output  1  executor busy; commands are ignored while high.
REQ-014 concluido  output  1  one-cycle pulse on completion of a command.
REQ-015 direcao  output  2  heading: 0 N, 1 E, 2 S, 3 W.
REQ-016 pos_x  output  4  x coordinate.
REQ-017 pos_y  output  4  y coordinate.
REQ-018 remocoes  output  8  count of completed removals.
REQ-019 erro  output  1  sticky flag: conflicting commands or wall-limit hit.

Function
REQ-020 The block SHALL implement states OCIOSO, AVANCANDO, GIRANDO, REMOVENDO with a down-counter of 8 bits.
REQ-021 In OCIOSO at a rising edge, the block SHALL accept one command, priority remover > girar > avancar, entering the matching state and loading the counter with T-1.
REQ-022 Outputs SHALL decode the registered state: motor_frente = AVANCANDO, motor_giro = GIRANDO, garra = REMOVENDO, ocupado = not OCIOSO.
REQ-023 For a command accepted at edge k, the drive output and ocupado SHALL be high for exactly T cycles (edges k..k+T), returning to OCIOSO at edge k+T.
REQ-024 At edge k+T the block SHALL update odometry and drive concluido high for exactly that one following cycle.
REQ-025 Commands present while ocupado is high SHALL be ignored and not queued; earliest next acceptance is edge k+T+1 (back-to-back period T+1).
REQ-026 AVANCANDO completion SHALL move one cell along direcao: N y+1, E x+1, S y-1, W x-1.
REQ-027 A move that would leave 0..GRID_MAX SHALL leave the coordinate unchanged and set erro.
REQ-028 GIRANDO completion SHALL set direcao to (direcao+1) mod 4 (clockwise), wrapping 3 -> 0.
REQ-029 REMOVENDO completion SHALL increment remocoes, saturating at 255.
REQ-030 More than one command high at an accepting edge SHALL set erro while the highest-priority command still executes.
REQ-031 erro SHALL remain high until reset.
REQ-032 No command high in OCIOSO SHALL leave all state unchanged.

Reset
REQ-033 reset high SHALL immediately, independent of clock, force state OCIOSO, counter 0, all drive outputs 0, ocupado 0, concluido 0, direcao 0, pos_x 0, pos_y 0, remocoes 0, erro 0.
REQ-034 Reset asserted mid-command SHALL abort it with no odometry update and no concluido pulse.
REQ-035 After reset release, the first rising edge SHALL be able to accept a command.

Verification
REQ-036 avancar one cycle from reset -> motor_frente and ocupado high 4 cycles, concluido pulse, pos_y=1, pos_x=0, erro=0.
REQ-037 girar held high 5 operations -> each motor_giro 3 cycles, period 4, direcao 1,2,3,0,1.
REQ-038 avancar+remover together at idle -> garra 6 cycles, remocoes=1, pos unchanged, erro=1 sticky.
REQ-039 girar x3 (heading W) then avancar at x=0 -> motor_frente 4 cycles, pos_x stays 0, erro=1.
REQ-040 remover accepted, reset asserted on cycle 3 of garra -> all outputs 0 immediately, remocoes=0, no concluido.
REQ-041 girar pulsed on cycle 2 of an AVANCANDO operation -> ignored, direcao unchanged, pos_y=1 after completion.
